// File: rtl/cmpfeed.sv
// cmpfeed: glyph bitmap slice feeder for the cmpalu compare accelerator.
// Holds a 64x24 bitmap written by the host and streams it to cmpalu as
// column, top-down row and bottom-up row slices, then captures the result.
// Optional watchdog: define CMPFEED_TIMEOUT_EN to abort WAIT_DONE after
// TIMEOUT cycles without done (pulses timeout); otherwise timeout is tied 0.
module cmpfeed #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_we,
  input  logic [5:0]  load_addr,
  input  logic [23:0] load_data,
  input  logic        go,
  output logic        busy,
  output logic [12:0] res_out,
  output logic        res_valid,
  output logic        timeout,
  output logic        start,
  output logic [63:0] bitcolumn,
  output logic [23:0] bitrowtop,
  output logic [23:0] bitrowbot,
  output logic        nextcolumnready,
  output logic        nextrowtopready,
  output logic        nextrowbotready,
  output logic        lastcolumn,
  input  logic        nextcolumn,
  input  logic        nextrowtop,
  input  logic        nextrowbot,
  input  logic        done,
  input  logic [12:0] result
);

  localparam int unsigned ROWS = 64;
  localparam int unsigned COLS = 24;
  localparam int unsigned AW   = 6;
  localparam int unsigned CW   = 5;
  localparam int unsigned PW   = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  // The watchdog needs at least two cycles of headroom to count.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("cmpfeed: TIMEOUT must be at least 2");
  end

  state_t          state;
  logic [COLS-1:0] mem [ROWS];
  logic [CW-1:0]   col_cnt;
  logic [PW-1:0]   top_cnt;
  logic [PW-1:0]   bot_cnt;
  logic [1:0]      guard;

  logic [ROWS-1:0] col_slice;
  logic [CW-1:0]   col_bit;
  logic            done_ok;
  logic            stream_ok;
  logic            col_iss;
  logic            top_iss;
  logic            bot_iss;
  logic            all_out;

`ifdef CMPFEED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0] wcnt;
`else
  assign timeout = 1'b0;
`endif

  // Host bitmap writes, accepted only while idle; contents survive rst.
  always_ff @(posedge clk) begin
    if (load_we && (state == S_IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  // Column slice gather, issue decisions and done qualification.
  always_comb begin
    col_bit   = '0;
    col_slice = '0;
    if (col_cnt < CW'(COLS)) begin
      col_bit = CW'(COLS - 1) - col_cnt;
    end
    for (int r = 0; r < ROWS; r++) begin
      col_slice[r] = mem[r][col_bit];
    end
    // done is stale for two cycles after start; guard masks it.
    done_ok   = done && (guard == 2'd0) &&
                ((state == S_STREAM) || (state == S_WAIT_DONE));
    stream_ok = (state == S_STREAM) && !done_ok;
    // First slice of every stream goes out unconditionally from START.
    col_iss   = (state == S_START) ||
                (stream_ok && nextcolumn && !nextcolumnready && (col_cnt < CW'(COLS)));
    top_iss   = (state == S_START) ||
                (stream_ok && nextrowtop && !nextrowtopready && (top_cnt < PW'(ROWS)));
    bot_iss   = (state == S_START) ||
                (stream_ok && nextrowbot && !nextrowbotready && (bot_cnt < PW'(ROWS)));
    all_out   = (col_cnt == CW'(COLS)) && (top_cnt == PW'(ROWS)) && (bot_cnt == PW'(ROWS));
  end

  // Run control FSM with registered slice data, pulses and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      res_out         <= '0;
      res_valid       <= 1'b0;
      start           <= 1'b0;
      bitcolumn       <= '0;
      bitrowtop       <= '0;
      bitrowbot       <= '0;
      nextcolumnready <= 1'b0;
      nextrowtopready <= 1'b0;
      nextrowbotready <= 1'b0;
      lastcolumn      <= 1'b0;
      col_cnt         <= '0;
      top_cnt         <= '0;
      bot_cnt         <= '0;
      guard           <= '0;
`ifdef CMPFEED_TIMEOUT_EN
      timeout         <= 1'b0;
      wcnt            <= '0;
`endif
    end else begin
      start           <= 1'b0;
      res_valid       <= 1'b0;
`ifdef CMPFEED_TIMEOUT_EN
      timeout         <= 1'b0;
`endif
      nextcolumnready <= col_iss;
      nextrowtopready <= top_iss;
      nextrowbotready <= bot_iss;

      if (col_iss) begin
        bitcolumn <= col_slice;
        col_cnt   <= col_cnt + CW'(1);
        if (col_cnt == CW'(COLS - 1)) begin
          lastcolumn <= 1'b1;
        end
      end
      if (top_iss) begin
        bitrowtop <= mem[top_cnt[AW-1:0]];
        top_cnt   <= top_cnt + PW'(1);
      end
      if (bot_iss) begin
        bitrowbot <= mem[AW'(ROWS - 1) - bot_cnt[AW-1:0]];
        bot_cnt   <= bot_cnt + PW'(1);
      end

      if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_START;
            busy    <= 1'b1;
            start   <= 1'b1;
            col_cnt <= '0;
            top_cnt <= '0;
            bot_cnt <= '0;
          end
        end
        S_START: begin
          state <= S_STREAM;
          guard <= 2'd2;
        end
        S_STREAM: begin
          // Result is latched as done is sampled so res_valid lands one cycle later.
          if (done_ok) begin
            state     <= S_RESULT;
            res_out   <= result;
            res_valid <= 1'b1;
          end else if (all_out) begin
            state <= S_WAIT_DONE;
`ifdef CMPFEED_TIMEOUT_EN
            wcnt  <= TW'(1);
`endif
          end
        end
        S_WAIT_DONE: begin
          if (done_ok) begin
            state     <= S_RESULT;
            res_out   <= result;
            res_valid <= 1'b1;
          end
`ifdef CMPFEED_TIMEOUT_EN
          else if (wcnt == TW'(TIMEOUT - 1)) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            lastcolumn <= 1'b0;
            timeout    <= 1'b1;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
`endif
        end
        S_RESULT: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          lastcolumn <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmpfeed.sv
// tb_cmpfeed: self-checking bench for cmpfeed with a stub cmpalu consumer.
module tb_cmpfeed;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic        load_we;
  logic [5:0]  load_addr;
  logic [23:0] load_data;
  logic        go;
  logic        busy;
  logic [12:0] res_out;
  logic        res_valid;
  logic        timeout;
  logic        start;
  logic [63:0] bitcolumn;
  logic [23:0] bitrowtop;
  logic [23:0] bitrowbot;
  logic        nextcolumnready;
  logic        nextrowtopready;
  logic        nextrowbotready;
  logic        lastcolumn;
  logic        nextcolumn;
  logic        nextrowtop;
  logic        nextrowbot;
  logic        done;
  logic [12:0] result;

  cmpfeed #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .go(go), .busy(busy), .res_out(res_out),
    .res_valid(res_valid), .timeout(timeout), .start(start),
    .bitcolumn(bitcolumn), .bitrowtop(bitrowtop), .bitrowbot(bitrowbot),
    .nextcolumnready(nextcolumnready), .nextrowtopready(nextrowtopready),
    .nextrowbotready(nextrowbotready), .lastcolumn(lastcolumn),
    .nextcolumn(nextcolumn), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
    .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          mode;    // 0 next held 1, 1 echo ready 2 cycles later, 2 bottom stalled
    bit          single;  // one pixel at row 40 column 5, else random bitmap
    bit          reload;  // rewrite bitmap before go
    bit          poke;    // load/go attempt while busy
    logic [12:0] res;
    int          ncol;
    int          ntop;
    int          nbot;
    bit          timed;   // check slice cycle positions
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stub_mode = 0;
  int start_cnt = 0, start_cyc = 0;
  int rv_cnt = 0, rv_cyc = 0;
  int to_cnt = 0, to_cyc = 0;
  logic to_busy = 1'b0;
  logic [12:0] rv_val = '0;
  logic [23:0] model_mem [64];
  logic [63:0] col_q [$];
  logic [23:0] top_q [$];
  logic [23:0] bot_q [$];
  int col_t [$];
  int top_t [$];
  int bot_t [$];
  logic lc_q [$];
  logic c_d1 = 0, c_d2 = 0, t_d1 = 0, t_d2 = 0, b_d1 = 0, b_d2 = 0;
  vec_t vecs [5];
  vec_t post;

  // Output monitor and stub consumer, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (nextcolumnready) begin col_q.push_back(bitcolumn); col_t.push_back(cyc); lc_q.push_back(lastcolumn); end
    if (nextrowtopready) begin top_q.push_back(bitrowtop); top_t.push_back(cyc); end
    if (nextrowbotready) begin bot_q.push_back(bitrowbot); bot_t.push_back(cyc); end
    if (res_valid) begin rv_cnt++; rv_cyc = cyc; rv_val = res_out; end
    if (timeout) begin to_cnt++; to_cyc = cyc; to_busy = busy; end
    case (stub_mode)
      1: begin
        nextcolumn = c_d2; c_d2 = c_d1; c_d1 = nextcolumnready;
        nextrowtop = t_d2; t_d2 = t_d1; t_d1 = nextrowtopready;
        nextrowbot = b_d2; b_d2 = b_d1; b_d1 = nextrowbotready;
      end
      2: begin nextcolumn = 1'b1; nextrowtop = 1'b1; nextrowbot = 1'b0; end
      default: begin nextcolumn = 1'b1; nextrowtop = 1'b1; nextrowbot = 1'b1; end
    endcase
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_col(input int k);
    logic [63:0] w;
    w = '0;
    for (int r = 0; r < 64; r++) w[r] = model_mem[r][23 - k];
    return w;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " ctrl"}, 64'({busy, res_valid, timeout, start, lastcolumn,
                             nextcolumnready, nextrowtopready, nextrowbotready}), 64'd0);
    chk({tag, " res_out"}, 64'(res_out), 64'd0);
    chk({tag, " bitcolumn"}, bitcolumn, 64'd0);
    chk({tag, " rows"}, 64'({bitrowtop, bitrowbot}), 64'd0);
  endtask

  task automatic clear_q();
    col_q.delete(); top_q.delete(); bot_q.delete();
    col_t.delete(); top_t.delete(); bot_t.delete(); lc_q.delete();
  endtask

  // Load (optionally), start, stream, deliver done and check everything.
  task automatic run_vec(input vec_t v, input string tag);
    int sc0, rc0, tc0, s, d, n;
    logic [23:0] w;
    sc0 = start_cnt; rc0 = rv_cnt; tc0 = to_cnt;
    stub_mode = v.mode;
    clear_q();
    if (v.reload) begin
      for (int r = 0; r < 64; r++) begin
        w = v.single ? ((r == 40) ? 24'h040000 : 24'h000000) : 24'($urandom);
        model_mem[r] = w;
        load_we = 1'b1; load_addr = 6'(r); load_data = w;
        go = (r == 63);
        tick();
      end
    end else begin
      go = 1'b1;
      tick();
    end
    load_we = 1'b0; go = 1'b0;
    chk({tag, " start pulse"}, 64'(start_cnt - sc0), 64'd1);
    s = start_cyc;
    // stale done during the first cycles after start must be ignored
    done = 1'b1; result = 13'h1fff;
    repeat (3) tick();
    done = 1'b0; result = '0;
    n = 0;
    while (!(col_q.size() >= v.ncol && top_q.size() >= v.ntop && bot_q.size() >= v.nbot) && n < 700) begin
      if (v.poke && cyc == s + 5) begin
        load_we = 1'b1; load_addr = 6'd0; load_data = ~model_mem[0]; go = 1'b1;
      end else begin
        load_we = 1'b0; go = 1'b0;
      end
      tick();
      n++;
    end
    load_we = 1'b0; go = 1'b0;
    repeat (8) tick();
    chk({tag, " col count"}, 64'(col_q.size()), 64'(v.ncol));
    chk({tag, " top count"}, 64'(top_q.size()), 64'(v.ntop));
    chk({tag, " bot count"}, 64'(bot_q.size()), 64'(v.nbot));
    for (int k = 0; k < col_q.size() && k < v.ncol; k++)
      chk($sformatf("%s col%0d", tag, k), col_q[k], exp_col(k));
    for (int k = 0; k < top_q.size() && k < v.ntop; k++)
      chk($sformatf("%s top%0d", tag, k), 64'(top_q[k]), 64'(model_mem[k]));
    for (int k = 0; k < bot_q.size() && k < v.nbot; k++)
      chk($sformatf("%s bot%0d", tag, k), 64'(bot_q[k]), 64'(model_mem[63 - k]));
    if (lc_q.size() >= 24) begin
      chk({tag, " lastcol before 23"}, 64'(lc_q[22]), 64'd0);
      chk({tag, " lastcol at 23"}, 64'(lc_q[23]), 64'd1);
    end
    if (v.timed && col_t.size() >= 24 && top_t.size() >= 64 && bot_t.size() >= 64) begin
      chk({tag, " first col cyc"}, 64'(col_t[0] - s), 64'd1);
      chk({tag, " last col cyc"}, 64'(col_t[23] - s), 64'd47);
      chk({tag, " last top cyc"}, 64'(top_t[63] - s), 64'd127);
      chk({tag, " last bot cyc"}, 64'(bot_t[63] - s), 64'd127);
    end
    chk({tag, " busy mid"}, 64'(busy), 64'd1);
    chk({tag, " no early result"}, 64'(rv_cnt - rc0), 64'd0);
    d = cyc;
    done = 1'b1; result = v.res;
    tick();
    done = 1'b0; result = '0;
    chk({tag, " res_valid count"}, 64'(rv_cnt - rc0), 64'd1);
    chk({tag, " res_valid cyc"}, 64'(rv_cyc - d), 64'd1);
    chk({tag, " res_out"}, 64'(rv_val), 64'(v.res));
    repeat (2) tick();
    chk({tag, " busy end"}, 64'(busy), 64'd0);
    chk({tag, " lastcol end"}, 64'(lastcolumn), 64'd0);
    chk({tag, " single start"}, 64'(start_cnt - sc0), 64'd1);
    chk({tag, " no timeout"}, 64'(to_cnt - tc0), 64'd0);
  endtask

  // Synchronous reset 30 cycles into a run.
  task automatic reset_mid_run();
    int sc0, rc0, s;
    sc0 = start_cnt; rc0 = rv_cnt;
    stub_mode = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("midrst start", 64'(start_cnt - sc0), 64'd1);
    s = start_cyc;
    while (cyc < s + 30) tick();
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    tick();
    chk("midrst no result", 64'(rv_cnt - rc0), 64'd0);
  endtask

  // All-empty bitmap: cmpalu never answers.
  task automatic timeout_seq();
    int rc0, tc0, s, d, n;
    rc0 = rv_cnt; tc0 = to_cnt;
    stub_mode = 0;
    clear_q();
    for (int r = 0; r < 64; r++) begin
      model_mem[r] = '0;
      load_we = 1'b1; load_addr = 6'(r); load_data = '0; go = (r == 63);
      tick();
    end
    load_we = 1'b0; go = 1'b0;
    s = start_cyc;
`ifdef CMPFEED_TIMEOUT_EN
    n = 0;
    while (to_cnt == tc0 && n < 400) begin tick(); n++; end
    chk("to count", 64'(to_cnt - tc0), 64'd1);
    chk("to cycle", 64'(to_cyc - s), 64'(127 + TO));
    chk("to busy", 64'(to_busy), 64'd0);
    repeat (3) tick();
    chk("to busy after", 64'(busy), 64'd0);
    chk("to no result", 64'(rv_cnt - rc0), 64'd0);
    d = 0;
`else
    n = 0;
    while (cyc < s + 127 + TO + 40) tick();
    chk("wait no timeout", 64'(to_cnt - tc0), 64'd0);
    chk("wait busy", 64'(busy), 64'd1);
    chk("wait no result", 64'(rv_cnt - rc0), 64'd0);
    d = cyc;
    done = 1'b1; result = 13'h0abc;
    tick();
    done = 1'b0; result = '0;
    chk("wait res_valid cyc", 64'(rv_cyc - d), 64'd1);
    chk("wait res_out", 64'(rv_val), 64'h0abc);
    repeat (2) tick();
    chk("wait busy end", 64'(busy), 64'd0);
`endif
    chk("empty col count", 64'(col_q.size()), 64'd24);
    chk("empty bot count", 64'(bot_q.size()), 64'd64);
  endtask

  initial begin
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; go = 1'b0;
    done = 1'b0; result = '0;
    nextcolumn = 1'b1; nextrowtop = 1'b1; nextrowbot = 1'b1;
    for (int r = 0; r < 64; r++) model_mem[r] = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    vecs[0] = '{0, 1'b1, 1'b1, 1'b0, 13'h12e5, 24, 64, 64, 1'b1};
    vecs[1] = '{1, 1'b0, 1'b1, 1'b0, 13'($urandom), 24, 64, 64, 1'b0};
    vecs[2] = '{2, 1'b0, 1'b1, 1'b0, 13'($urandom), 24, 64, 1, 1'b0};
    vecs[3] = '{0, 1'b0, 1'b1, 1'b1, 13'($urandom), 24, 64, 64, 1'b1};
    vecs[4] = '{1, 1'b0, 1'b0, 1'b0, 13'($urandom), 24, 64, 64, 1'b0};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    reset_mid_run();
    post = '{0, 1'b0, 1'b0, 1'b0, 13'($urandom), 24, 64, 64, 1'b1};
    run_vec(post, "postrst");

    timeout_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmpfeed.md
# cmpfeed

Bitmap slice feeder for the compare accelerator. Holds a 64-row x 24-column glyph bitmap written by the host, then streams it to `cmpalu` over that block's three slice handshakes: columns left-to-right, rows top-down, and rows bottom-up. On `cmpalu` completion it captures the 13-bit shift/scale result for the host. It is the producer end of the `cmpalu` slice interface.

## Interface
- `TIMEOUT`, 256: cycles to wait for `done` after all three streams are exhausted (used only with `CMPFEED_TIMEOUT_EN`).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_we`  in  1  write one bitmap row; ignored unless IDLE.
- `load_addr`  in  6  row index, 0 = top.
- `load_data`  in  24  row pixels; bit 23 = leftmost.
- `go`  in  1  start a run; ignored unless IDLE.
- `busy`  out  1  high in every state except IDLE.
- `res_out`  out  13  captured `cmpalu` result.
- `res_valid`  out  1  one-cycle pulse when `res_out` updates.
- `timeout`  out  1  one-cycle pulse on watchdog abort.
- `start`  out  1  one-cycle reset pulse to `cmpalu`.
- `bitcolumn`  out  64  column slice; bit r = pixel of row r.
- `bitrowtop`, `bitrowbot`  out  24 each  row slices.
- `nextcolumnready`, `nextrowtopready`, `nextrowbotready`  out  1 each  slice-valid pulses.
- `lastcolumn`  out  1  final-column flag.
- `nextcolumn`, `nextrowtop`, `nextrowbot`  in  1 each  consumer "slice checked" levels.
- `done`  in  1,  `result`  in  13  from `cmpalu`.

## Operation
- Storage: 64 x 24 register array; contents survive runs and `rst`.
- FSM: IDLE -> START on `go`. START: `start`=1 for one cycle, clear pointers -> STREAM. STREAM -> WAIT_DONE when all streams are exhausted. From STREAM or WAIT_DONE: `done`=1 -> RESULT. RESULT: latch `result` into `res_out`, pulse `res_valid`, -> IDLE.
- Streams run independently and concurrently:
  - Column pointer runs 0..23; column k uses array bit (23-k) of every row.
  - Top pointer runs 0..63.
  - Bottom pointer runs 63..0.
- Issue rule per stream:
  - The first slice issues in the cycle after START, regardless of the consumer level.
  - Each later slice issues when the matching `next*` input is 1, its `*ready` output is currently 0, and slices remain.
  - Data and ready are registered together. Data holds after the pulse.
- `lastcolumn` is set with the column-23 pulse and held until IDLE.
- A stream stops at its end. The top and bottom streams are never truncated early.
- `done` is ignored for the first 2 cycles after the `start` pulse, because the consumer's `done` is stale then.
- `rst` mid-run: return to IDLE, all outputs 0, no `res_valid`. The next `go` re-pulses `start`.

## Timing
- Reset value of every output: 0, including `res_out`.
- Steady state: one slice per stream every 2 cycles (pulse, consumer clears, consumer checks).
- Stream end, measured from the start cycle: last column pulse at cycle 1+2·23 = 47; last row pulses at cycle 1+2·63 = 127.
- `res_valid` fires 1 cycle after `done` is sampled.
- `go` together with `load_we` in IDLE: the write is performed and the run starts next cycle using the new data.

## Configuration
- `CMPFEED_TIMEOUT_EN` defined:
  - WAIT_DONE counts cycles. At `TIMEOUT` without `done`: pulse `timeout`, leave `res_out` unchanged, go to IDLE.
  - This case occurs for an all-empty bitmap, where `cmpalu` never finds a boundary.
- Not defined: no counter, `timeout` is tied 0, and WAIT_DONE waits indefinitely.

## Test plan
- Load one pixel at row 40, column 5 (bit 18); `go` with real `cmpalu` attached -> one `res_valid`, `res_out` = 13'h12E5 (lshift 5, dshift 23, vscale 1, hscale 0).
- Stub consumer that echoes each `*ready` back 2 cycles later as `next*`=1 -> exactly 24/64/64 pulses; `lastcolumn` rises with the 24th column pulse; the column-0 word equals the array bit-23 slice; the bottom stream's first word is row 63.
- Stub holds `nextrowbot`=0 after the first pulse -> bottom stream stalls with no extra pulses; top and column streams complete normally.
- All-zero bitmap with the macro defined and `TIMEOUT`=16 -> `timeout` pulses 16 cycles after the streams end; `res_valid` never fires; `busy` falls.
- Assert `rst` at cycle 30 of a run -> next cycle all outputs are 0 and the FSM is IDLE; a following `go` re-pulses `start` and the run completes correctly.
- `load_we` and `go` while `busy` -> array unchanged and no second `start` pulse.
